// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C master arbiter.
package i2c_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        COMPLETE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. With a single request that requester wins;
// with both, the one named by ptr wins. Output is one-hot (or zero).
module rr_arb2
    import i2c_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] win
);

    // Contention is the only case that needs the pointer
    always_comb begin
        win = req;
        if (&req) win = ptr ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master core between two requesters: round-robin pick,
// latch the winner's command, one start pulse, route done/rdata/err back.
// Optional macro I2C_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog that forces
// completion with err=1 after TIMEOUT_CYCLES.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_rnw,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err,
    output logic [DATA_W-1:0]     rdata,
    output logic                  m_start,
    output logic                  m_rnw,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_done,
    input  logic                  m_ack_err,
    input  logic [DATA_W-1:0]     m_rdata
);

    arb_state_e         state;
    logic               ptr;    // requester favoured on contention
    logic               wsel;   // index of the current winner
    logic [NUM_REQ-1:0] win;

    rr_arb2 u_arb (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             timeout;

    assign timeout = (to_cnt == CNT_W'(TIMEOUT_CYCLES));
`endif

    // Arbitration FSM; every output is registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            wsel    <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            rdata   <= '0;
            m_start <= 1'b0;
            m_rnw   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            m_start <= 1'b0;
            done    <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        // Command fields are frozen here; later changes are ignored
                        wsel    <= win[1];
                        gnt     <= win;
                        m_start <= 1'b1;
                        m_rnw   <= win[1] ? req_rnw[1] : req_rnw[0];
                        m_addr  <= win[1] ? req_addr[ADDR_W +: ADDR_W]
                                          : req_addr[0 +: ADDR_W];
                        m_wdata <= win[1] ? req_wdata[DATA_W +: DATA_W]
                                          : req_wdata[0 +: DATA_W];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // m_done takes precedence over a simultaneous timeout
                    if (m_done) begin
                        rdata <= m_rdata;
                        err   <= m_ack_err;
                        done  <= gnt;
                        state <= COMPLETE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (timeout) begin
                        err   <= 1'b1;
                        done  <= gnt;
                        state <= COMPLETE;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
`endif
                end
                COMPLETE: begin
                    // Hand priority to the other requester; grant drops entering IDLE
                    gnt   <= '0;
                    ptr   <= ~wsel;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: a directed vector table,
// hand-written reset/ignore/timeout sequences and randomized transactions
// checked against a transaction-level round-robin model.
module tb_i2c_master_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  req_rnw = '0;
    logic [13:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  gnt, done;
    logic        err, m_start, m_rnw;
    logic [7:0]  rdata, m_wdata;
    logic [6:0]  m_addr;
    logic        m_done = 1'b0;
    logic        m_ack_err = 1'b0;
    logic [7:0]  m_rdata = '0;

    int vectors = 0;
    int miscompares = 0;
    int start_cnt = 0;
    logic       ptr_m = 1'b0;     // model: requester favoured on contention
    logic [7:0] last_rdata = '0;  // model: rdata holds between completions

    typedef struct {
        logic [1:0]  rq;
        logic [1:0]  rnw;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic        ack;
        logic [7:0]  mrd;
        int          dly;
        logic        keep;
        logic [1:0]  e_gnt;
        logic        e_rnw;
        logic [6:0]  e_addr;
        logic [7:0]  e_wdata;
        logic        e_err;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t tbl[6];

    i2c_master_arbiter #(.ADDR_W(7), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .m_start(m_start), .m_rnw(m_rnw),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_done(m_done),
        .m_ack_err(m_ack_err), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (m_start) start_cnt++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        ptr_m = 1'b0;
        last_rdata = '0;
    endtask

    // Expected grant and latched fields from the round-robin rules
    function automatic vec_t make_exp(input vec_t v);
        vec_t r;
        int w;
        r = v;
        w = (v.rq == 2'b11) ? int'(ptr_m) : ((v.rq == 2'b10) ? 1 : 0);
        r.e_gnt   = 2'(1 << w);
        r.e_rnw   = v.rnw[w];
        r.e_addr  = v.addr[w*7 +: 7];
        r.e_wdata = v.wdata[w*8 +: 8];
        r.e_err   = v.ack;
        r.e_rdata = v.mrd;
        return r;
    endfunction

    task automatic wait_start(input string tag);
        int n = 0;
        while (m_start !== 1'b1 && n < 8) begin tick(); n++; end
        chk({tag, ".m_start"}, m_start, 1);
    endtask

    // One complete transaction: request, grant, master completion, done
    task automatic do_txn(input vec_t v, input string tag);
        req_rnw = v.rnw; req_addr = v.addr; req_wdata = v.wdata; req = v.rq;
        wait_start(tag);
        chk({tag, ".gnt"}, gnt, v.e_gnt);
        chk({tag, ".m_rnw"}, m_rnw, v.e_rnw);
        chk({tag, ".m_addr"}, m_addr, v.e_addr);
        chk({tag, ".m_wdata"}, m_wdata, v.e_wdata);
        if (!v.keep) req = 2'b00;
        tick();
        chk({tag, ".start_1cyc"}, m_start, 0);
        chk({tag, ".gnt_hold"}, gnt, v.e_gnt);
        repeat (v.dly) begin
            m_ack_err = 1'($urandom); m_rdata = 8'($urandom);
            tick();
        end
        m_done = 1'b1; m_ack_err = v.ack; m_rdata = v.mrd;
        tick();
        m_done = 1'b0; m_ack_err = 1'b0; m_rdata = '0;
        chk({tag, ".done"}, done, v.e_gnt);
        chk({tag, ".err"}, err, v.e_err);
        chk({tag, ".rdata"}, rdata, v.e_rdata);
        chk({tag, ".gnt_at_done"}, gnt, v.e_gnt);
        tick();
        chk({tag, ".done_1cyc"}, done, 0);
        chk({tag, ".gnt_clear"}, gnt, 0);
        ptr_m = v.e_gnt[0];
        last_rdata = v.e_rdata;
    endtask

    initial begin
        vec_t v;
        int n;
        int s0;

        tbl[0] = '{2'b01, 2'b00, {7'h00, 7'h42}, {8'h00, 8'hA5}, 1'b0, 8'h00, 2, 1'b0,
                   2'b01, 1'b0, 7'h42, 8'hA5, 1'b0, 8'h00};
        tbl[1] = '{2'b10, 2'b10, {7'h50, 7'h11}, {8'h77, 8'h00}, 1'b0, 8'h3C, 1, 1'b0,
                   2'b10, 1'b1, 7'h50, 8'h77, 1'b0, 8'h3C};
        tbl[2] = '{2'b11, 2'b01, {7'h22, 7'h33}, {8'hBB, 8'hCC}, 1'b0, 8'h11, 0, 1'b1,
                   2'b01, 1'b1, 7'h33, 8'hCC, 1'b0, 8'h11};
        tbl[3] = '{2'b11, 2'b01, {7'h22, 7'h33}, {8'hBB, 8'hCC}, 1'b1, 8'h22, 3, 1'b1,
                   2'b10, 1'b0, 7'h22, 8'hBB, 1'b1, 8'h22};
        tbl[4] = '{2'b11, 2'b01, {7'h22, 7'h33}, {8'hBB, 8'hCC}, 1'b0, 8'h33, 1, 1'b1,
                   2'b01, 1'b1, 7'h33, 8'hCC, 1'b0, 8'h33};
        tbl[5] = '{2'b11, 2'b01, {7'h22, 7'h33}, {8'hBB, 8'hCC}, 1'b0, 8'h44, 0, 1'b0,
                   2'b10, 1'b0, 7'h22, 8'hBB, 1'b0, 8'h44};

        do_reset();
        chk("rst.gnt", gnt, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.m_start", m_start, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.m_rnw", m_rnw, 0);
        chk("rst.m_addr", m_addr, 0);
        chk("rst.m_wdata", m_wdata, 0);

        // Directed table: reset priority, read return, contention with NACK
        s0 = start_cnt;
        for (int i = 0; i < 6; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));
        chk("tbl.start_count", 32'(start_cnt - s0), 6);

        // Reset during WAIT_DONE: abort without done, priority back to 0
        req_rnw = 2'b00; req_addr = {7'h10, 7'h20}; req_wdata = 16'h1234; req = 2'b10;
        wait_start("midrst");
        req = 2'b00;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ptr_m = 1'b0; last_rdata = '0;
        chk("midrst.gnt", gnt, 0);
        chk("midrst.done", done, 0);
        chk("midrst.m_start", m_start, 0);
        // m_done outside WAIT_DONE must be ignored
        m_done = 1'b1; m_ack_err = 1'b1; m_rdata = 8'hFF;
        tick();
        m_done = 1'b0; m_ack_err = 1'b0; m_rdata = '0;
        n = 0;
        repeat (3) begin if (done != 2'b00) n++; tick(); end
        chk("idle_mdone.no_done", 32'(n), 0);
        chk("idle_mdone.err", err, 0);
        chk("idle_mdone.rdata", rdata, 0);
        v = tbl[2];
        v.keep = 1'b0;
        do_txn(make_exp(v), "midrst.rr");

        // Randomized transactions against the round-robin model
        for (int i = 0; i < 20; i++) begin
            v.rq    = 2'($urandom_range(1, 3));
            v.rnw   = 2'($urandom);
            v.addr  = 14'($urandom);
            v.wdata = 16'($urandom);
            v.ack   = 1'($urandom);
            v.mrd   = 8'($urandom);
            v.dly   = $urandom_range(0, 4);
            v.keep  = 1'b0;
            do_txn(make_exp(v), $sformatf("rnd%0d", i));
        end

        // Master never answers
        req_rnw = 2'b01; req_addr = {7'h00, 7'h55}; req_wdata = 16'h0000; req = 2'b01;
        wait_start("hang");
        req = 2'b00;
        n = 0;
`ifdef I2C_ARB_TIMEOUT_EN
        while (done !== 2'b01 && n < 100) begin tick(); n++; end
        chk("timeout.latency", 32'(n), 18);
        chk("timeout.done", done, 2'b01);
        chk("timeout.err", err, 1);
        chk("timeout.rdata", rdata, last_rdata);
        tick();
        chk("timeout.gnt_clear", gnt, 0);
`else
        repeat (1000) begin if (done != 2'b00) n++; tick(); end
        chk("hang.no_done", 32'(n), 0);
        chk("hang.gnt_held", gnt, 2'b01);
        do_reset();
        chk("hang.rst_gnt", gnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
